// File: rtl/div_rs_ctrl_pkg.sv
// Shared definitions for the repeated-subtraction divider controller.
// Holds FSM state encodings and the default operand width.
// No logic; imported by the controller and the bench.
package div_rs_ctrl_pkg;

    localparam int DIV_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_rs_ctrl_sub_nbit.sv
// W-bit ripple-borrow subtractor: diff = a - b, borrow = (a < b).
// Latency: purely combinational, borrow ripples LSB to MSB.
// Backpressure: none; borrow-in of the chain is tied to 0.
module sub_nbit #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    // Chain of full-subtractor cells, carrying the borrow upward bit by bit.
    always_comb begin
        logic bin;
        diff   = '0;
        bin    = 1'b0;
        for (int i = 0; i < W; i++) begin
            diff[i] = a[i] ^ b[i] ^ bin;
            bin     = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bin);
        end
        borrow = bin;
    end

endmodule

// File: rtl/div_rs_ctrl.sv
// Unsigned divider: quotient/remainder by repeated subtraction on one shared subtractor.
// Latency: q+2 cycles from accepted start to done (1 cycle for a zero divisor).
// Backpressure: start is only honoured in IDLE; starts while busy/done are dropped.
module div_rs_ctrl
    import div_rs_ctrl_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);

    state_t       state_q, state_d;
    logic [W-1:0] quo_q, quo_d;
    logic [W-1:0] rem_q, rem_d;
    logic [W-1:0] dvs_q, dvs_d;
    logic         dbz_q, dbz_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic [W-1:0] sub_diff;
    logic         sub_borrow;

    // The single shared subtractor: running remainder minus latched divisor.
    sub_nbit #(.W(W)) u_sub (
        .a      (rem_q),
        .b      (dvs_q),
        .diff   (sub_diff),
        .borrow (sub_borrow)
    );

    // Next-state, operand capture and quotient counting.
    always_comb begin
        state_d = state_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        dbz_d   = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rem_d = dividend;
                    dvs_d = divisor;
                    if (divisor == '0) begin
                        // Divide by zero skips RUN entirely.
                        quo_d   = '1;
                        dbz_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        quo_d   = '0;
                        dbz_d   = 1'b0;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                // No borrow means remainder >= divisor (equality included).
                if (!sub_borrow) begin
                    rem_d = sub_diff;
                    quo_d = quo_q + {{(W-1){1'b0}}, 1'b1};
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Status flags are registered decodes of the next state so the
        // outputs come straight from flops.
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers; synchronous reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: doc/div_rs_ctrl.md
Name: div_rs_ctrl

Overview:
- Multi-cycle unsigned divider controller. It computes quotient and remainder by repeated subtraction, sequencing one shared W-bit ripple-borrow subtractor (full-subtractor chain, borrow-in tied 0).
- Each RUN cycle issues one subtract and uses the borrow-out as the "remainder < divisor" decision.
- Sits beside the existing add/sub datapath as the first sequenced arithmetic unit.

Parameters:
- W, 4, operand / quotient / remainder width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  W  unsigned dividend; captured on accepted start.
- divisor  input  W  unsigned divisor; captured on accepted start.
- quotient  output  W  result quotient; registered.
- remainder  output  W  result remainder; registered.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse; results valid.
- div_by_zero  output  1  registered; set when the captured divisor is 0.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high on rst, and takes priority over everything including start.
- Reset values: state=IDLE, quotient=0, remainder=0, busy=0, done=0, div_by_zero=0, internal divisor register=0.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE, start=1, divisor!=0:
  - Next cycle: RUN.
  - remainder<=dividend, quotient<=0, div_by_zero<=0, divisor latched.
- IDLE, start=1, divisor==0:
  - Next cycle: DONE; no subtraction performed.
  - quotient<=all ones, remainder<=dividend, div_by_zero<=1.
- IDLE, start=0: hold state; outputs hold their last values.
- RUN: the subtractor computes remainder - divisor_reg combinationally.
  - borrow=0: remainder<=diff, quotient<=quotient+1, stay in RUN.
  - borrow=1: remainder and quotient unchanged, go to DONE.
- DONE: done=1 for exactly this cycle, busy=0; next cycle IDLE unconditionally.
- Latency: start sampled at edge T →
  - nonzero divisor: q+1 RUN cycles, done high in cycle T+q+2;
  - zero divisor: done high in cycle T+1.
  - Worst case (W=4, 15/1): done at T+17.
- start while in RUN or DONE is ignored; it is neither queued nor an error. Operand inputs are don't-care outside an accepted start.
- Quotient overflow: with divisor>=1, quotient<=dividend<=2^W-1, so the quotient never overflows and no saturation logic is needed.
- Equality: dividend==divisor gives quotient=1, remainder=0, because borrow=0 when the difference is 0.
- Results (quotient, remainder, div_by_zero) hold after done until the next accepted start or rst.
- rst asserted mid-RUN: next cycle IDLE with all reset values; no done pulse for the aborted operation.
- Outputs are pure register outputs; no combinational path from inputs to outputs.

Decomposition:
- Shared package/header holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - default width constant DIV_W=4.
- One sub-module: sub_nbit. It is a W-parameterised ripple chain of full-subtractor cells with borrow-in 0 and ports a, b, diff, borrow. The controller instantiates exactly one.
- Controller owns the FSM, the quotient counter and the operand registers.

Test Plan:
- 13/4: start pulse at T → busy for 4 cycles; done at T+5; quotient=3, remainder=1, div_by_zero=0.
- 3/5 (dividend<divisor): done at T+2; quotient=0, remainder=3. Also check 4/4 → quotient=1, remainder=0 at T+3.
- 15/1 worst case: busy for 16 cycles; done at T+17; quotient=15, remainder=0. done is exactly one cycle wide.
- 7/0: done at T+1; busy never asserted; quotient=4'hF, remainder=7, div_by_zero=1. A following 9/3 clears div_by_zero and gives quotient=3, remainder=0.
- start held high through a 12/5 operation → second start ignored until IDLE; first result quotient=2, remainder=2 at T+4. A new operation begins only after DONE→IDLE.
- rst asserted during RUN of 15/1 (at T+5) → next cycle all outputs 0, state IDLE, no done pulse; a subsequent 6/2 completes normally with quotient=3, remainder=0.
